rns_rev_conv_seq: RTL and testbench

- Multi-cycle sequencer for reverse conversion from the residue number system (RNS) to binary.
- Moduli set: {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}.
- Accepts one residue tuple over a valid/ready handshake and steps it through fixed stages: S1/S3 differences, P (3-moduli value X123), S2/S4 (fourth-modulus digit), combine.
- Returns the binary value X over a second valid/ready handshake. Processes one tuple at a time.

---
 rtl/rns_pkg.sv | 87 ++++++++
 rtl/rns_mod_sub.sv | 53 +++++
 rtl/rns_rev_conv_seq.sv | 208 ++++++++++++++++++++
 tb/tb_rns_rev_conv_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rns_pkg
//  Purpose  : Shared types and elaboration-time constants for the RNS
//             {2^N-1, 2^N, 2^N+1, 2^(N+1)-1} to binary reverse converter.
//             Holds the FSM state enum, default width constants and helper
//             functions returning the moduli, M123 and inv(M123 mod m4).
//  Revision : 1.0 - initial release
// ============================================================================
package rns_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_S13  = 3'd2,
        ST_P    = 3'd3,
        ST_S24  = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // Widths for the default N = 8 build; the top derives its own from N.
    localparam int N_DEF = 8;
    localparam int XW    = 4 * N_DEF + 1;
    localparam int RW    = N_DEF + 1;

    function automatic int xw_f(input int n);
        return 4 * n + 1;
    endfunction

    function automatic int rw_f(input int n);
        return n + 1;
    endfunction

    function automatic longint m1_f(input int n);
        return (longint'(1) << n) - 1;
    endfunction

    function automatic longint m2_f(input int n);
        return longint'(1) << n;
    endfunction

    function automatic longint m3_f(input int n);
        return (longint'(1) << n) + 1;
    endfunction

    function automatic longint m4_f(input int n);
        return (longint'(1) << (n + 1)) - 1;
    endfunction

    // M123 = 2^N * (2^2N - 1)
    function automatic longint m123_f(input int n);
        return (longint'(1) << n) * ((longint'(1) << (2 * n)) - 1);
    endfunction

    // Extended Euclid; a and m must be coprime (true for even N).
    function automatic longint mod_inv(input longint a, input longint m);
        longint t;
        longint nt;
        longint r;
        longint nr;
        longint q;
        longint tmp;
        t  = 0;
        nt = 1;
        r  = m;
        nr = a;
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt;
            t   = nt;
            nt  = tmp;
            tmp = r - q * nr;
            r   = nr;
            nr  = tmp;
        end
        if (t < 0) begin
            t = t + m;
        end
        return t;
    endfunction

    function automatic longint inv_f(input int n);
        return mod_inv(m123_f(n) % m4_f(n), m4_f(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rns_mod_sub.sv
`default_nettype none
// ============================================================================
//  Module   : rns_mod_sub
//  Purpose  : Combinational modular subtractor d = (a - b) mod M.
//             Each operand is first brought into [0, M) by one conditional
//             subtract, so operands must be below 2M; an operand equal to M
//             maps to 0. For M = 2^OW-1 the difference uses an end-around
//             carry adder; otherwise add (M - b) then conditionally subtract M.
//  Ports    : a [AW] minuend, b [BW] subtrahend, d [OW] canonical result.
//  Revision : 1.0 - initial release
// ============================================================================
module rns_mod_sub #(
    parameter int     AW = 8,
    parameter int     BW = 8,
    parameter int     OW = 8,
    parameter longint M  = 255
) (
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [OW-1:0] d
);

    localparam int c_IW = ((AW > BW) ? ((AW > OW) ? AW : OW)
                                     : ((BW > OW) ? BW : OW)) + 1;
    localparam logic [c_IW-1:0] c_MI = c_IW'(M);

    logic [c_IW-1:0] w_a_ext;
    logic [c_IW-1:0] w_b_ext;
    logic [OW-1:0]   w_ar;
    logic [OW-1:0]   w_br;

    assign w_a_ext = {{(c_IW-AW){1'b0}}, a};
    assign w_b_ext = {{(c_IW-BW){1'b0}}, b};
    assign w_ar    = (w_a_ext >= c_MI) ? OW'(w_a_ext - c_MI) : OW'(w_a_ext);
    assign w_br    = (w_b_ext >= c_MI) ? OW'(w_b_ext - c_MI) : OW'(w_b_ext);

    if (M == ((longint'(1) << OW) - 1)) begin : g_eac
        // ~b is -b in one's complement; fold the carry back in and map the
        // all-ones negative zero onto 0.
        logic [OW:0]   w_s;
        logic [OW-1:0] w_e;
        assign w_s = {1'b0, w_ar} + {1'b0, ~w_br};
        assign w_e = w_s[OW-1:0] + {{(OW-1){1'b0}}, w_s[OW]};
        assign d   = (&w_e) ? '0 : w_e;
    end else begin : g_gen
        localparam logic [OW:0] c_MO = (OW+1)'(M);
        logic [OW:0] w_s;
        assign w_s = {1'b0, w_ar} + (c_MO - {1'b0, w_br});
        assign d   = (w_s >= c_MO) ? OW'(w_s - c_MO) : w_s[OW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/rns_rev_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rns_rev_conv_seq
//  Purpose  : Multi-cycle RNS-to-binary reverse converter for the moduli set
//             {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}, one tuple at a time.
//             Stages: CHK -> S13 (d1,d3) -> P (X123) -> S24 (k, combine) -> OUT.
//  Ports    : clk, rst (async, active high)
//             in_valid/in_ready, r1[N], r2[N], r3[N+1], r4[N+1]  - input tuple
//             out_valid/out_ready, x[4N+1], err                   - result
//  Config   : RNS_REV_CONV_RANGE_CHK_EN enables the non-canonical residue
//             check in CHK (err=1, x=0); undefined, err is tied 0 and
//             out-of-range residues are reduced by one conditional subtract.
//  Revision : 1.0 - initial release
// ============================================================================
module rns_rev_conv_seq
    import rns_pkg::*;
#(
    parameter int N = 8     // even, 4..16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] r1,
    input  logic [N-1:0] r2,
    input  logic [N:0]   r3,
    input  logic [N:0]   r4,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4*N:0] x,
    output logic         err
);

    localparam int                c_XW   = xw_f(N);
    localparam int                c_RW   = rw_f(N);
    localparam logic [c_XW-1:0]   c_M123 = c_XW'(m123_f(N));
    localparam logic [c_RW-1:0]   c_M4   = c_RW'(m4_f(N));
    localparam logic [c_RW-1:0]   c_INV  = c_RW'(inv_f(N));

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_r1;
    logic [N-1:0]      r_r2;
    logic [N:0]        r_r3;
    logic [N:0]        r_r4;
    logic [N-1:0]      r_d1;
    logic [N:0]        r_d3;
    logic [3*N-1:0]    r_x123;
    logic [c_XW-1:0]   r_x;

    logic [N-1:0]      w_d1;
    logic [N:0]        w_d3;
    logic [N-1:0]      w_t;
    logic [N-1:0]      w_trot;
    logic [2*N-1:0]    w_p1;
    logic [3*N+2:0]    w_x123_pad;
    logic [N+2:0]      w_sum1;
    logic [N+1:0]      w_xm4;
    logic [N:0]        w_diff4;
    logic [2*N+1:0]    w_prod;
    logic [N+1:0]      w_kf;
    logic [N:0]        w_k;
    logic [c_XW-1:0]   w_x_nxt;

    // ---------------- S13: first-level differences -------------------------
    rns_mod_sub #(.AW(N), .BW(N), .OW(N), .M(m1_f(N))) u_sub_d1 (
        .a(r_r1), .b(r_r2), .d(w_d1)
    );

    rns_mod_sub #(.AW(N), .BW(N+1), .OW(N+1), .M(m3_f(N))) u_sub_d3 (
        .a(r_r2), .b(r_r3), .d(w_d3)
    );

    // ---------------- P: X123 = r2 + 2^N * p1 ------------------------------
    // p1 = d3 + m3*t with t = (d1 - d3) * inv(m3) mod m1. Since m3 = 2 mod m1,
    // inv(m3) = 2^(N-1), which is a rotate-right by one in mod 2^N-1.
    rns_mod_sub #(.AW(N), .BW(N+1), .OW(N), .M(m1_f(N))) u_sub_t (
        .a(r_d1), .b(r_d3), .d(w_t)
    );

    assign w_trot = {w_t[0], w_t[N-1:1]};
    assign w_p1   = {w_trot, {N{1'b0}}} + {{N{1'b0}}, w_trot}
                  + {{(N-1){1'b0}}, r_d3};

    // ---------------- S24: k and combine ----------------------------------
    // X123 mod (2^(N+1)-1): fold (N+1)-bit chunks twice; result < 2*m4, so
    // the subtractor's single conditional subtract finishes the reduction.
    assign w_x123_pad = {3'b000, r_x123};
    assign w_sum1 = {2'b00, w_x123_pad[N:0]}
                  + {2'b00, w_x123_pad[2*N+1:N+1]}
                  + {2'b00, w_x123_pad[3*N+2:2*N+2]};
    assign w_xm4  = {1'b0, w_sum1[N:0]} + {{(N-1){1'b0}}, w_sum1[N+2:N+1]};

    rns_mod_sub #(.AW(N+1), .BW(N+2), .OW(N+1), .M(m4_f(N))) u_sub_k (
        .a(r_r4), .b(w_xm4), .d(w_diff4)
    );

    // Full-width product, then one fold plus conditional subtract mod m4.
    assign w_prod = (2*N+2)'(w_diff4) * (2*N+2)'(c_INV);
    assign w_kf   = {1'b0, w_prod[N:0]} + {1'b0, w_prod[2*N+1:N+1]};
    assign w_k    = (w_kf >= {1'b0, c_M4}) ? c_RW'(w_kf - {1'b0, c_M4})
                                           : w_kf[N:0];

    assign w_x_nxt = c_XW'(r_x123) + c_M123 * c_XW'(w_k);

`ifdef RNS_REV_CONV_RANGE_CHK_EN
    localparam logic [N-1:0]    c_M1 = N'(m1_f(N));
    localparam logic [c_RW-1:0] c_M3 = c_RW'(m3_f(N));
    logic r_err;
    logic w_bad;
    assign w_bad = (r_r1 >= c_M1) || (r_r3 >= c_M3) || (r_r4 >= c_M4);
    assign err   = r_err;
`else
    assign err   = 1'b0;
`endif

    // ---------------- FSM -------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK:  w_state_nxt = ST_S13;
`ifdef RNS_REV_CONV_RANGE_CHK_EN
            // The verdict registered in CHK diverts a bad tuple to OUT here.
            ST_S13:  w_state_nxt = r_err ? ST_OUT : ST_P;
`else
            ST_S13:  w_state_nxt = ST_P;
`endif
            ST_P:    w_state_nxt = ST_S24;
            ST_S24:  w_state_nxt = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Datapath registers ---------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r1   <= '0;
            r_r2   <= '0;
            r_r3   <= '0;
            r_r4   <= '0;
            r_d1   <= '0;
            r_d3   <= '0;
            r_x123 <= '0;
            r_x    <= '0;
`ifdef RNS_REV_CONV_RANGE_CHK_EN
            r_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_r1 <= r1;
                        r_r2 <= r2;
                        r_r3 <= r3;
                        r_r4 <= r4;
                    end
                end
                ST_CHK: begin
                    r_x <= '0;
`ifdef RNS_REV_CONV_RANGE_CHK_EN
                    r_err <= w_bad;
`endif
                end
                ST_S13: begin
                    r_d1 <= w_d1;
                    r_d3 <= w_d3;
                end
                ST_P: begin
                    r_x123 <= {w_p1, r_r2};
                end
                ST_S24: begin
                    r_x <= w_x_nxt;
`ifdef RNS_REV_CONV_RANGE_CHK_EN
                    r_err <= 1'b0;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign x = r_x;

endmodule
`default_nettype wire

// File: tb/tb_rns_rev_conv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rns_rev_conv_seq
//  Purpose  : Directed self-checking bench for rns_rev_conv_seq (N = 8).
//             Expected values are hand-computed residues of known integers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rns_rev_conv_seq;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  r1;
    logic [N-1:0]  r2;
    logic [N:0]    r3;
    logic [N:0]    r4;
    logic          out_valid;
    logic          out_ready;
    logic [4*N:0]  x;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [4*N:0] got_q[$];

    rns_rev_conv_seq #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(x);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Waits for in_ready (sampled at negedge), presents the tuple and returns
    // the cycle count just after the accepting edge.
    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N:0] c, input logic [N:0] d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", in_ready, 1);
        r1 = a; r2 = b; r3 = c; r4 = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, output int lat);
        while (!out_valid && (cyc - acc) < 20) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - acc;
    endtask

    task automatic run_vec(input string tag,
                           input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N:0] c, input logic [N:0] d,
                           input logic [4*N:0] ex, input logic ee, input int el);
        int acc;
        int lat;
        push(a, b, c, d, acc);
        wait_out(acc, lat);
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_x"}, x, ex);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_busy"}, in_ready, 0);
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        int acc0;
        int acc1;
        int acc2;
        int lat;
        logic [4*N:0] exp_b2b [3];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        r1 = '0; r2 = '0; r3 = '0; r4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1000 = (1000 mod 255, mod 256, mod 257, mod 511)
        run_vec("v1000", 8'd235, 8'd232, 9'd229, 9'd489, 33'd1000, 1'b0, 4);
        run_vec("vzero", 8'd0, 8'd0, 9'd0, 9'd0, 33'd0, 1'b0, 4);
        run_vec("vmax", 8'd254, 8'd255, 9'd256, 9'd510, 33'd8573026559, 1'b0, 4);
        // 65280 = 255*256 -> (0, 0, 2, 383)
        run_vec("v65280", 8'd0, 8'd0, 9'd2, 9'd383, 33'd65280, 1'b0, 4);
`ifdef RNS_REV_CONV_RANGE_CHK_EN
        run_vec("vrange", 8'd235, 8'd232, 9'd300, 9'd489, 33'd0, 1'b1, 2);
`else
        run_vec("vr1max", 8'd255, 8'd0, 9'd2, 9'd383, 33'd65280, 1'b0, 4);
`endif

        // Stall at OUT with a competing tuple offered while busy.
        out_ready = 1'b0;
        push(8'd235, 8'd232, 9'd229, 9'd489, acc0);
        wait_out(acc0, lat);
        chk("stall_lat", lat, 4);
        r1 = 8'd0; r2 = 8'd0; r3 = 9'd2; r4 = 9'd383;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_x", x, 1000);
            chk("stall_ov", out_valid, 1);
            chk("stall_ir", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_idle_ov", out_valid, 0);
        chk("stall_idle_ir", in_ready, 1);
        @(posedge clk);
        #1;
        acc1 = cyc;
        in_valid = 1'b0;
        chk("stall_accept", in_ready, 0);
        wait_out(acc1, lat);
        chk("stall2_lat", lat, 4);
        chk("stall2_x", x, 65280);
        @(posedge clk);
        #1;

        // Reset while the tuple is in P.
        push(8'd254, 8'd255, 9'd256, 9'd510, acc0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_ir", in_ready, 1);
        chk("mrst_x", x, 0);
        chk("mrst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("mrst_quiet", out_valid, 0);
        end
        run_vec("mrst_next", 8'd235, 8'd232, 9'd229, 9'd489, 33'd1000, 1'b0, 4);

        // Back-to-back: busy span CHK..OUT is five cycles, accept in IDLE.
        got_q.delete();
        exp_b2b[0] = 33'd1000;
        exp_b2b[1] = 33'd8573026559;
        exp_b2b[2] = 33'd65280;
        push(8'd235, 8'd232, 9'd229, 9'd489, acc0);
        push(8'd254, 8'd255, 9'd256, 9'd510, acc1);
        push(8'd0, 8'd0, 9'd2, 9'd383, acc2);
        wait_out(acc2, lat);
        @(posedge clk);
        #1;
        chk("b2b_gap01", acc1 - acc0, 6);
        chk("b2b_gap12", acc2 - acc1, 6);
        chk("b2b_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_x", (i < got_q.size()) ? got_q[i] : '1, exp_b2b[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
